// File: rtl/rv32_pkg.sv
// ============================================================================
// rv32_pkg : shared RV32I branch encodings, resolved-entry type, LT compare
// Revision : 1.0
// ============================================================================
`default_nettype none

package rv32_pkg;

  typedef enum logic [1:0] {
    BR_OP_NONE = 2'd0,
    BR_OP_BR   = 2'd1,
    BR_OP_JAL  = 2'd2,
    BR_OP_JALR = 2'd3
  } br_op_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef struct packed {
    logic        is_op;
    logic        taken;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] link;
    logic        exc;
    logic        illegal;
  } br_res_t;

  // With differing signs the subtraction can overflow, so the answer comes
  // straight from rs1's sign bit instead.
  function automatic logic lt32(input logic [31:0] a, input logic [31:0] b,
                                input logic is_unsigned);
    logic [31:0] diff;
    diff = a - b;
    if (a[31] != b[31]) return is_unsigned ? ~a[31] : a[31];
    return diff[31];
  endfunction

endpackage

`default_nettype wire

// File: rtl/br_cond_eval.sv
// ============================================================================
// br_cond_eval : RV32I branch condition evaluation (combinational)
// Revision     : 1.0
// ============================================================================
`default_nettype none

module br_cond_eval
  import rv32_pkg::*;
(
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [2:0]  i_funct3,
  output logic        o_taken,
  output logic        o_illegal
);

  logic w_eq;
  logic w_lt;

  assign w_eq = (i_rs1 == i_rs2);
  assign w_lt = lt32(i_rs1, i_rs2, i_funct3[1]);

  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_BEQ:           o_taken = w_eq;
      F3_BNE:           o_taken = ~w_eq;
      F3_BLT, F3_BLTU:  o_taken = w_lt;
      F3_BGE, F3_BGEU:  o_taken = ~w_lt;
      default:          o_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// branch_resolve_unit : EX-stage branch/jump resolver, 2-entry skid output
// Optional macro BRU_STATS_EN adds branch / mispredict counters.
// Revision            : 1.0
// ============================================================================
`default_nettype none

module branch_resolve_unit
  import rv32_pkg::*;
#(
  parameter int          XLEN            = 32,
  parameter logic [31:0] RESET_PC_UNUSED = 32'h0
) (
  input  logic            clk,
  input  logic            rst,
`ifdef BRU_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts,
`endif
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_funct3,
  input  logic [1:0]      in_op,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_target,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic            out_redirect,
  output logic [XLEN-1:0] out_redirect_pc,
  output logic [XLEN-1:0] out_link,
  output logic            out_exc_misaligned,
  output logic            out_illegal
);

  localparam br_res_t c_RESET_ENT = '{is_op: 1'b0, taken: 1'b0, redirect: 1'b0,
                                      redirect_pc: RESET_PC_UNUSED,
                                      link: RESET_PC_UNUSED,
                                      exc: 1'b0, illegal: 1'b0};

  br_op_e      w_op;
  logic        w_cond_taken;
  logic        w_cond_illegal;
  logic [31:0] w_target;
  logic [31:0] w_pc4;
  br_res_t     w_res;
  logic        w_push;
  logic        w_pop;

  br_res_t     r_main;
  br_res_t     r_skid;
  logic        r_main_v;
  logic        r_skid_v;

  br_cond_eval u_cond (
    .i_rs1     (in_rs1),
    .i_rs2     (in_rs2),
    .i_funct3  (in_funct3),
    .o_taken   (w_cond_taken),
    .o_illegal (w_cond_illegal)
  );

  assign w_op     = br_op_e'(in_op);
  assign w_pc4    = in_pc + 32'd4;
  assign w_target = (w_op == BR_OP_JALR) ? ((in_rs1 + in_imm) & ~32'd1)
                                         : (in_pc + in_imm);

  always_comb begin
    w_res       = '0;
    w_res.is_op = (w_op != BR_OP_NONE);
    case (w_op)
      BR_OP_BR: begin
        w_res.taken   = w_cond_taken;
        w_res.illegal = w_cond_illegal;
      end
      BR_OP_JAL, BR_OP_JALR: w_res.taken = 1'b1;
      default:               w_res.taken = 1'b0;
    endcase
    w_res.link        = w_res.is_op ? w_pc4 : 32'd0;
    w_res.exc         = w_res.taken && (w_target[1:0] != 2'b00);
    w_res.redirect_pc = w_res.taken ? w_target : w_pc4;
    // A misaligned target traps, and the trap handler owns the refetch.
    w_res.redirect    = !w_res.exc &&
                        ((w_res.taken != in_pred_taken) ||
                         (w_res.taken && (w_target != in_pred_target)));
  end

  assign in_ready = ~r_skid_v;
  assign w_push   = in_valid && in_ready && !flush;
  assign w_pop    = r_main_v && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
      r_main   <= c_RESET_ENT;
      r_skid   <= c_RESET_ENT;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (!r_main_v || w_pop) begin
      if (r_skid_v) begin
        r_main   <= r_skid;
        r_main_v <= 1'b1;
        r_skid_v <= w_push;
        if (w_push) r_skid <= w_res;
      end else begin
        r_main_v <= w_push;
        if (w_push) r_main <= w_res;
      end
    end else if (w_push) begin
      r_skid   <= w_res;
      r_skid_v <= 1'b1;
    end
  end

  assign out_valid          = r_main_v;
  assign out_taken          = r_main.taken;
  assign out_redirect       = r_main.redirect;
  assign out_redirect_pc    = r_main.redirect_pc;
  assign out_link           = r_main.link;
  assign out_exc_misaligned = r_main.exc;
  assign out_illegal        = r_main.illegal;

`ifdef BRU_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mp;

  // Counting follows the output handshake, which still completes under flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_br <= 32'd0;
      r_stat_mp <= 32'd0;
    end else if (w_pop) begin
      if (r_main.is_op && (r_stat_br != 32'hFFFF_FFFF))
        r_stat_br <= r_stat_br + 32'd1;
      if (r_main.redirect && (r_stat_mp != 32'hFFFF_FFFF))
        r_stat_mp <= r_stat_mp + 32'd1;
    end
  end

  assign stat_branches    = r_stat_br;
  assign stat_mispredicts = r_stat_mp;
`else
  logic w_unused_stats;
  assign w_unused_stats = r_main.is_op;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
// ============================================================================
// tb_branch_resolve_unit : directed table, corner sequences, random scoreboard
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_branch_resolve_unit;

  logic        clk, rst, flush;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_rs1, in_rs2, in_imm, in_pred_target;
  logic [2:0]  in_funct3;
  logic [1:0]  in_op;
  logic        in_pred_taken;
  logic        out_taken, out_redirect, out_exc_misaligned, out_illegal;
  logic [31:0] out_redirect_pc, out_link;
`ifdef BRU_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  branch_resolve_unit dut (
    .clk(clk), .rst(rst),
`ifdef BRU_STATS_EN
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts),
`endif
    .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .in_funct3(in_funct3), .in_op(in_op), .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target), .out_valid(out_valid), .out_ready(out_ready),
    .out_taken(out_taken), .out_redirect(out_redirect),
    .out_redirect_pc(out_redirect_pc), .out_link(out_link),
    .out_exc_misaligned(out_exc_misaligned), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        isop;
    logic        taken;
    logic        redirect;
    logic [31:0] rpc;
    logic [31:0] link;
    logic        exc;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] pc, rs1, rs2, imm, ptgt;
    logic [2:0]  f3;
    logic [1:0]  op;
    logic        pt;
    exp_t        e;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  exp_t q[$];
  int unsigned m_br, m_mp;

  // Reference: architectural meaning of each instruction, no datapath detail.
  function automatic exp_t model(input logic [31:0] pc, rs1, rs2, imm,
                                 input logic [2:0] f3, input logic [1:0] op,
                                 input logic pt, input logic [31:0] ptgt);
    exp_t e;
    logic [31:0] tgt;
    e.isop = (op != 2'd0);
    e.ill  = (op == 2'd1) && (f3 == 3'd2 || f3 == 3'd3);
    e.taken = 1'b0;
    if (op == 2'd2 || op == 2'd3) e.taken = 1'b1;
    else if (op == 2'd1) begin
      case (f3)
        3'd0: e.taken = (rs1 == rs2);
        3'd1: e.taken = (rs1 != rs2);
        3'd4: e.taken = ($signed(rs1) <  $signed(rs2));
        3'd5: e.taken = ($signed(rs1) >= $signed(rs2));
        3'd6: e.taken = (rs1 <  rs2);
        3'd7: e.taken = (rs1 >= rs2);
        default: e.taken = 1'b0;
      endcase
    end
    tgt      = (op == 2'd3) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    e.link   = e.isop ? pc + 32'd4 : 32'd0;
    e.exc    = e.taken && (tgt % 4 != 0);
    e.rpc    = e.taken ? tgt : pc + 32'd4;
    e.redirect = !e.exc && ((e.taken != pt) || (e.taken && tgt != ptgt));
    return e;
  endfunction

  function automatic vec_t mkv(input logic [31:0] pc, rs1, rs2, imm,
                               input logic [2:0] f3, input logic [1:0] op,
                               input logic pt, input logic [31:0] ptgt,
                               input logic tk, rd, input logic [31:0] rpc, lnk,
                               input logic ex, il);
    vec_t v;
    v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.f3 = f3; v.op = op;
    v.pt = pt; v.ptgt = ptgt;
    v.e.isop = (op != 2'd0); v.e.taken = tk; v.e.redirect = rd;
    v.e.rpc = rpc; v.e.link = lnk; v.e.exc = ex; v.e.ill = il;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, " taken"},    32'(out_taken),          32'(e.taken));
    chk({tag, " redirect"}, 32'(out_redirect),       32'(e.redirect));
    chk({tag, " rpc"},      out_redirect_pc,         e.rpc);
    chk({tag, " link"},     out_link,                e.link);
    chk({tag, " exc"},      32'(out_exc_misaligned), 32'(e.exc));
    chk({tag, " illegal"},  32'(out_illegal),        32'(e.ill));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, rs1, rs2, imm, input logic [2:0] f3,
                       input logic [1:0] op, input logic pt, input logic [31:0] ptgt);
    in_pc = pc; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_funct3 = f3;
    in_op = op; in_pred_taken = pt; in_pred_target = ptgt; in_valid = 1'b1;
  endtask

  task automatic rand_inputs();
    logic [31:0] pc, rs1, rs2, imm, tgt;
    logic [1:0]  op;
    pc  = $urandom & 32'hFFFF_FFFC;
    rs1 = ($urandom % 2 == 0) ? $urandom : ($urandom % 8) - 32'd4;
    rs2 = ($urandom % 4 == 0) ? rs1 : (($urandom % 2 == 0) ? $urandom : ($urandom % 8) - 32'd4);
    imm = ($urandom % 8 == 0) ? ($urandom & 32'hFFFF_FFFE) : ($urandom & 32'hFFFF_FFFC);
    op  = 2'($urandom % 4);
    tgt = (op == 2'd3) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    drive(pc, rs1, rs2, imm, 3'($urandom % 8), op, 1'($urandom % 2),
          ($urandom % 2 == 0) ? tgt : $urandom);
    in_valid  = ($urandom % 4 != 0);
    out_ready = ($urandom % 3 != 0);
    flush     = ($urandom % 20 == 0);
  endtask

  vec_t tbl[10];
  exp_t ej;
  logic acc, pop;
  int   rst_done;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0);
    in_valid = 1'b0;
    tick(); tick();
    chk("rst in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    tick();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    ej = '{isop: 1'b0, taken: 1'b0, redirect: 1'b0, rpc: 32'd0, link: 32'd0, exc: 1'b0, ill: 1'b0};
    check_out("reset", ej);

    tbl[0] = mkv(32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 3'd4, 2'd1, 1'b0, 32'h0,
                 1'b1, 1'b1, 32'h120, 32'h104, 1'b0, 1'b0);
    tbl[1] = mkv(32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 3'd6, 2'd1, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h104, 32'h104, 1'b0, 1'b0);
    tbl[2] = mkv(32'h100, 32'hFFFF_FFFF, 32'd1, 32'h20, 3'd6, 2'd1, 1'b1, 32'h120,
                 1'b0, 1'b1, 32'h104, 32'h104, 1'b0, 1'b0);
    tbl[3] = mkv(32'h200, 32'h2003, 32'd0, 32'h0, 3'd0, 2'd3, 1'b0, 32'h0,
                 1'b1, 1'b0, 32'h2002, 32'h204, 1'b1, 1'b0);
    tbl[4] = mkv(32'h300, 32'd5, 32'd5, 32'hFFFF_FFF8, 3'd0, 2'd1, 1'b1, 32'h2F8,
                 1'b1, 1'b0, 32'h2F8, 32'h304, 1'b0, 1'b0);
    tbl[5] = mkv(32'h400, 32'd1, 32'd2, 32'h40, 3'd2, 2'd1, 1'b1, 32'h440,
                 1'b0, 1'b1, 32'h404, 32'h404, 1'b0, 1'b1);
    tbl[6] = mkv(32'h500, 32'd0, 32'd0, 32'h100, 3'd0, 2'd2, 1'b1, 32'h600,
                 1'b1, 1'b0, 32'h600, 32'h504, 1'b0, 1'b0);
    tbl[7] = mkv(32'h600, 32'd0, 32'd0, 32'h0, 3'd0, 2'd0, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h604, 32'h0, 1'b0, 1'b0);
    tbl[8] = mkv(32'h700, 32'h8000_0000, 32'd0, 32'h10, 3'd5, 2'd1, 1'b0, 32'h0,
                 1'b0, 1'b0, 32'h704, 32'h704, 1'b0, 1'b0);
    tbl[9] = mkv(32'h700, 32'h8000_0000, 32'd0, 32'h10, 3'd7, 2'd1, 1'b0, 32'h0,
                 1'b1, 1'b1, 32'h710, 32'h704, 1'b0, 1'b0);

    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].pc, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, tbl[i].f3, tbl[i].op,
            tbl[i].pt, tbl[i].ptgt);
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      check_out($sformatf("vec%0d", i), tbl[i].e);
      tick();
      chk($sformatf("vec%0d drained", i), 32'(out_valid), 32'd0);
    end
`ifdef BRU_STATS_EN
    chk("stat_branches", stat_branches, 32'd9);
    chk("stat_mispredicts", stat_mispredicts, 32'd4);
`endif

    // Backpressure: three offers, two accepted, released in order.
    out_ready = 1'b0;
    drive(32'h1000, 0, 0, 32'h40, 3'd0, 2'd2, 1'b1, 32'h1040);
    tick();
    drive(32'h2000, 0, 0, 32'h40, 3'd0, 2'd2, 1'b1, 32'h2040);
    chk("bp second ready", 32'(in_ready), 32'd1);
    tick();
    drive(32'h3000, 0, 0, 32'h40, 3'd0, 2'd2, 1'b1, 32'h3040);
    chk("bp full ready", 32'(in_ready), 32'd0);
    tick();
    chk("bp held ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp first rpc", out_redirect_pc, 32'h1040);
    chk("bp first link", out_link, 32'h1004);
    tick();
    chk("bp second valid", 32'(out_valid), 32'd1);
    chk("bp second rpc", out_redirect_pc, 32'h2040);
    tick();
    chk("bp no third", 32'(out_valid), 32'd0);

    // Flush with both entries full and a beat on offer.
    out_ready = 1'b0;
    drive(32'h1000, 0, 0, 32'h40, 3'd0, 2'd2, 1'b1, 32'h1040);
    tick();
    drive(32'h2000, 0, 0, 32'h40, 3'd0, 2'd2, 1'b1, 32'h2040);
    tick();
    drive(32'h3000, 0, 0, 32'h40, 3'd0, 2'd2, 1'b1, 32'h3040);
    flush = 1'b1;
    chk("fl full ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl out_valid", 32'(out_valid), 32'd0);
    chk("fl in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("fl dropped", 32'(out_valid), 32'd0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete(); m_br = 0; m_mp = 0; rst_done = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rand_inputs();
      chk("rnd in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("rnd out_valid", 32'(out_valid), 32'(q.size() > 0));
      if (q.size() > 0) check_out("rnd", q[0]);
`ifdef BRU_STATS_EN
      chk("rnd stat_branches", stat_branches, m_br);
      chk("rnd stat_mispredicts", stat_mispredicts, m_mp);
`endif
      if (((cyc >= 1000 && rst_done == 0) || (cyc >= 2000 && rst_done == 1)) && q.size() > 0) begin
        rst_done++;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst in_ready", 32'(in_ready), 32'd1);
`ifdef BRU_STATS_EN
        chk("async rst stat_branches", stat_branches, 32'd0);
        chk("async rst stat_mispredicts", stat_mispredicts, 32'd0);
`endif
        tick();
        rst = 1'b0;
        q.delete(); m_br = 0; m_mp = 0;
      end else begin
        acc = in_valid && (q.size() < 2) && !flush;
        pop = (q.size() > 0) && out_ready;
        ej  = model(in_pc, in_rs1, in_rs2, in_imm, in_funct3, in_op, in_pred_taken,
                    in_pred_target);
        tick();
        if (pop) begin
          if (q[0].isop && m_br != 32'hFFFF_FFFF) m_br++;
          if (q[0].redirect && m_mp != 32'hFFFF_FFFF) m_mp++;
        end
        if (flush) q.delete();
        else begin
          if (pop) void'(q.pop_front());
          if (acc) q.push_back(ej);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
